// File: rtl/bilbo_pkg.sv
// Shared encodings and default constants for the BILBO register slice.
// Imported by the datapath top and the session controller.
package bilbo_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT = 2'b00,
        MODE_CLEAR = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_STEP  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_CMP  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [7:0] POLY_DEFAULT = 8'h1D;
    localparam logic [7:0] SEED_DEFAULT = 8'h01;

endpackage

// File: rtl/bilbo_ctrl.sv
// BIST session controller: sequences start, stepping, compare and done.
// The datapath follows load/step_en; pass is registered at the compare.
module bilbo_ctrl
    import bilbo_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        start,
    input  logic        prpg,
    input  logic        match,
    input  logic [15:0] run_cycles,
    output logic        load,
    output logic        step_en,
    output logic        prpg_s,
    output logic        busy,
    output logic        done,
    output logic        pass
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        prpg_q, prpg_d;
    logic        pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prpg_d  = prpg_q;
        pass_d  = pass_q;
        load    = 1'b0;
        step_en = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = run_cycles;
                    prpg_d  = prpg;
                    pass_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q != 16'd0) begin
                    step_en = 1'b1;
                    cnt_d   = cnt_q - 16'd1;
                end else begin
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                pass_d  = match;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            prpg_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prpg_q  <= prpg_d;
            pass_q  <= pass_d;
        end
    end

    assign prpg_s = prpg_q;
    assign busy   = (state_q == ST_RUN) || (state_q == ST_CMP);
    assign done   = (state_q == ST_DONE);
    assign pass   = pass_q;

endmodule

// File: rtl/bilbo_reg_n.sv
// BILBO register: scan / clear / capture / MISR-PRPG with shadow output
// and a self-timed signature-check session.
module bilbo_reg_n
    import bilbo_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_DEFAULT),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEFAULT)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             prpg,
    input  logic [WIDTH-1:0] data,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic             update,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] sig,
    input  logic             start,
    input  logic [15:0]      run_cycles,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             load, step_en, prpg_s, match;

    function automatic logic [WIDTH-1:0] step_f(
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] d
    );
        return {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? POLY : '0) ^ d;
    endfunction

    assign match = (r_q == golden);

    bilbo_ctrl u_ctrl (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .prpg       (prpg),
        .match      (match),
        .run_cycles (run_cycles),
        .load       (load),
        .step_en    (step_en),
        .prpg_s     (prpg_s),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
    );

    always_comb begin
        r_d      = r_q;
        shadow_d = shadow_q;
        if (load) begin
            r_d = prpg ? SEED : '0;
        end else if (busy) begin
            if (step_en) r_d = step_f(r_q, prpg_s ? '0 : data);
        end else begin
            case (mode_e'(mode))
                MODE_SHIFT: r_d = {r_q[WIDTH-2:0], scan_in};
                MODE_CLEAR: r_d = '0;
                MODE_LOAD:  r_d = data;
                MODE_STEP:  r_d = step_f(r_q, prpg ? '0 : data);
                default:    r_d = r_q;
            endcase
        end
        // Session cycles leave the shadow alone so q stays stable.
        if (!busy && update) shadow_d = r_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_q      <= '0;
            shadow_q <= '0;
        end else begin
            r_q      <= r_d;
            shadow_q <= shadow_d;
        end
    end

    assign scan_out = r_q[WIDTH-1];
    assign sig      = r_q;
    assign q        = en ? shadow_q : data;

endmodule

// File: tb/tb_bilbo_reg_n.sv
// Directed bench for bilbo_reg_n with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each clock edge.
module tb_bilbo_reg_n;

    logic        clock = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        prpg;
    logic [7:0]  data;
    logic        scan_in;
    logic        scan_out;
    logic        update;
    logic        en;
    logic [7:0]  q;
    logic [7:0]  sig;
    logic        start;
    logic [15:0] run_cycles;
    logic [7:0]  golden;
    logic        busy;
    logic        done;
    logic        pass;

    int n_tests = 0;
    int n_fail  = 0;

    bilbo_reg_n dut (
        .clock      (clock),
        .rst        (rst),
        .mode       (mode),
        .prpg       (prpg),
        .data       (data),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .update     (update),
        .en         (en),
        .q          (q),
        .sig        (sig),
        .start      (start),
        .run_cycles (run_cycles),
        .golden     (golden),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    logic [7:0] scan_bits;
    logic [7:0] scan_model;
    int         nb;

    initial begin
        rst = 1'b1; mode = 2'b01; prpg = 1'b0; data = 8'h3C;
        scan_in = 1'b0; update = 1'b0; en = 1'b0; start = 1'b0;
        run_cycles = 16'd0; golden = 8'h00;
        tick();
        rst = 1'b0;
        check("rst_sig", sig, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_scan_out", scan_out, 1'b0);
        check("rst_q_bypass", q, 8'h3C);
        en = 1'b1;
        #1;
        check("rst_q_shadow", q, 8'h00);
        en = 1'b0;

        // scan shift 1,0,1,0,... then keep shifting zeros
        mode = 2'b00;
        scan_bits = 8'b0101_0101;
        scan_model = 8'h00;
        for (int i = 0; i < 8; i++) begin
            scan_in = scan_bits[i];
            tick();
            scan_model = {scan_model[6:0], scan_bits[i]};
            check("scan_out", scan_out, scan_model[7]);
        end
        check("scan_sig_AA", sig, 8'hAA);
        check("scan_out_first", scan_out, 1'b1);
        scan_in = 1'b0;
        tick();
        check("scan_sig_54", sig, 8'h54);
        check("scan_out_second", scan_out, 1'b0);

        mode = 2'b01;
        tick();
        check("clear_sig", sig, 8'h00);

        // capture, shadow update, bypass
        mode = 2'b10; data = 8'h5A;
        tick();
        check("load_sig", sig, 8'h5A);
        update = 1'b1;
        tick();
        update = 1'b0; en = 1'b1;
        #1;
        check("q_shadow_5A", q, 8'h5A);
        data = 8'h33;
        tick();
        check("load_sig_33", sig, 8'h33);
        check("q_shadow_hold", q, 8'h5A);
        en = 1'b0;
        #1;
        check("q_bypass_33", q, 8'h33);
        en = 1'b1;

        // PRPG session; start wins over mode=clear
        mode = 2'b01; prpg = 1'b1; run_cycles = 16'd8; golden = 8'h1D;
        start = 1'b1;
        tick();
        start = 1'b0; update = 1'b1; mode = 2'b10; data = 8'hC3;
        check("prpg_seed", sig, 8'h01);
        check("prpg_busy", busy, 1'b1);
        wait_idle(nb);
        update = 1'b0;
        check("prpg_busy_cycles", nb, 10);
        check("prpg_sig", sig, 8'h1D);
        check("prpg_done", done, 1'b1);
        check("prpg_pass", pass, 1'b1);
        check("prpg_q_no_update", q, 8'h5A);

        // MISR session, matching golden
        prpg = 1'b0; data = 8'hFF; run_cycles = 16'd2; golden = 8'h1C;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("misr_start_sig", sig, 8'h00);
        check("misr_start_done", done, 1'b0);
        check("misr_start_pass", pass, 1'b0);
        wait_idle(nb);
        check("misr_busy_cycles", nb, 4);
        check("misr_sig", sig, 8'h1C);
        check("misr_pass", pass, 1'b1);
        check("misr_done", done, 1'b1);

        // MISR session, wrong golden
        golden = 8'h1D;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(nb);
        check("misr2_sig", sig, 8'h1C);
        check("misr2_pass", pass, 1'b0);
        check("misr2_done", done, 1'b1);
        tick();
        check("misr2_done_hold", done, 1'b1);
        check("misr2_pass_hold", pass, 1'b0);

        // run_cycles = 0: compares the seed
        prpg = 1'b1; run_cycles = 16'd0; golden = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("zero_cmp_busy", busy, 1'b1);
        check("zero_cmp_done", done, 1'b0);
        tick();
        check("zero_done", done, 1'b1);
        check("zero_pass", pass, 1'b1);
        check("zero_sig", sig, 8'h01);

        // long session; mode churn must not disturb it; then abort
        prpg = 1'b1; run_cycles = 16'd100; golden = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = 2'b10; data = 8'hAA;
        tick();
        mode = 2'b00; scan_in = 1'b1;
        tick();
        mode = 2'b11; prpg = 1'b0; data = 8'hFF;
        tick();
        check("run_mode_ignored", sig, 8'h08);
        check("run_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 2'b01;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_pass", pass, 1'b0);
        check("abort_sig", sig, 8'h00);
        check("abort_q", q, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bilbo_reg_n.md
BILBO_REG_N -- requirements
Module: bilbo_reg_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (>=4).
REQ-002 SHALL have parameter POLY, default 8'h1D, Galois feedback taps (x^8+x^4+x^3+x^2+1); bit 0 set.
REQ-003 SHALL have parameter SEED, default 8'h01, nonzero PRPG start value.
REQ-004 SHALL have ports `clock` (in, 1, sole clock) and `rst` (in, 1); reset is synchronous and active-high.
REQ-005 SHALL have `mode` in 2: 00 scan shift, 01 clear, 10 normal capture, 11 MISR/PRPG step.
REQ-006 SHALL have `prpg` in 1: in MISR step or session, 1 = autonomous LFSR (data ignored), 0 = MISR compaction.
REQ-007 SHALL have `data` in WIDTH, functional input and MISR input.
REQ-008 SHALL have `scan_in` in 1 and `scan_out` out 1; scan_out = reg[WIDTH-1].
REQ-009 SHALL have `update` in 1: loads the shadow register.
REQ-010 SHALL have `en` in 1: output select.
REQ-011 SHALL have `q` out WIDTH: functional output.
REQ-012 SHALL have `sig` out WIDTH: current register contents.
REQ-013 SHALL have `start` in 1, `run_cycles` in 16 and `golden` in WIDTH: BIST session controls.
REQ-014 SHALL have `busy` out 1, `done` out 1 and `pass` out 1: session status.

Function
REQ-015 SHALL compute the step function step(r,d) = {r[WIDTH-2:0],0} ^ (r[WIDTH-1] ? POLY : 0) ^ d, with d = data for MISR and d = 0 for PRPG.
REQ-016 SHALL, in IDLE/DONE, update reg each cycle by mode: 00 reg <= {reg[WIDTH-2:0], scan_in}; 01 reg <= 0; 10 reg <= data; 11 reg <= step.
REQ-017 SHALL, while in IDLE/DONE, set shadow <= reg on update=1; otherwise shadow holds.
REQ-018 SHALL drive q = en ? shadow : data combinationally (bypass when en=0).
REQ-019 SHALL implement FSM states IDLE, RUN, CMP and DONE.
REQ-020 SHALL, on start=1 in IDLE or DONE, go to RUN, load reg with SEED if prpg=1 else 0, load count with run_cycles, and clear done and pass.
REQ-021 SHALL, in RUN with count != 0, set reg <= step using the prpg value sampled at start and decrement count; with count == 0, go to CMP with reg held.
REQ-022 SHALL, in CMP, set pass <= (reg == golden) and go to DONE.
REQ-023 SHALL, in DONE, hold done=1 and pass until the next start or rst.
REQ-024 SHALL drive busy=1 in RUN and CMP, otherwise 0.
REQ-025 SHALL ignore mode, update and start while busy.
REQ-026 SHALL, for run_cycles=0, go RUN->CMP with no step, comparing the start value (SEED or 0).
REQ-027 SHALL give a session latency of start cycle + run_cycles steps + 1 (RUN exit) + 1 (CMP) before done=1.
REQ-028 SHALL give start priority over mode when both are asserted in IDLE/DONE.
REQ-029 SHALL let the 16-bit count cover up to 65535 steps with no wrap.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set reg=0, shadow=0, count=0, state=IDLE, busy=0, done=0, pass=0; scan_out is then 0 and q = en ? 0 : data.
REQ-031 SHALL give rst priority over start, mode and update, and SHALL abort any session mid-RUN/CMP with no pass update.

Structure
REQ-032 SHALL place mode encodings, FSM state encoding and the default POLY/SEED constants in shared package bilbo_pkg.
REQ-033 SHALL put the session FSM and counter in sub-module bilbo_ctrl; the datapath (reg, shadow, step function) SHALL stay in bilbo_reg_n.

Verification
REQ-034 SHALL cover: rst, then mode=00 with scan_in 1,0,1,0,1,0,1,0 over 8 cycles -> sig=8'hAA, scan_out follows the bit shifted in 8 cycles earlier.
REQ-035 SHALL cover: start with prpg=1, run_cycles=8, golden=8'h1D -> busy for 9 cycles + CMP, sig=8'h1D, done=1, pass=1.
REQ-036 SHALL cover: start with prpg=0, data=8'hFF, run_cycles=2, golden=8'h1C -> sig=8'h1C, pass=1; repeat with golden=8'h1D -> pass=0.
REQ-037 SHALL cover: mode=10, data=8'h5A, then update=1, en=1 -> q=8'h5A; then en=0, data=8'h33 -> q=8'h33.
REQ-038 SHALL cover: rst asserted mid-RUN -> next cycle busy=0, done=0, pass=0, sig=0; mode changes during RUN do not alter sig.
REQ-039 SHALL cover: run_cycles=0 with prpg=1 and golden=8'h01 -> pass=1 two cycles after RUN entry.
